// File: rtl/id_ex_operand_stage_pkg.sv
// rtl/id_ex_operand_stage_pkg.sv - shared ALU codes, forward-select enum and widths for the ID/EX stage
package id_ex_operand_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // ALU function codes; ADD must stay 0 so a zeroed bubble computes 0+0.
    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_OR  = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_SUB = 5'd3;
    localparam logic [4:0] ALU_SLT = 5'd4;
    localparam logic [4:0] ALU_NOR = 5'd5;
    localparam logic [4:0] ALU_XOR = 5'd6;
    localparam logic [4:0] ALU_SRL = 5'd7;
    localparam logic [4:0] ALU_SRA = 5'd8;
    localparam logic [4:0] ALU_SLL = 5'd9;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_fwd_select.sv
// rtl/id_ex_operand_stage_fwd_select.sv - RAW forward resolution for one source operand
module fwd_select #(
    parameter int DATA_W = id_ex_operand_stage_pkg::DATA_W,
    parameter int REG_W  = id_ex_operand_stage_pkg::REG_W
) (
    input  logic [REG_W-1:0]  src_idx,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_dst,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_dst,
    input  logic [DATA_W-1:0] memwb_wdata,
    output logic [DATA_W-1:0] fwd_data
);
    import id_ex_operand_stage_pkg::*;

    logic     exmem_hit;
    logic     memwb_hit;
    fwd_sel_e sel;

    // $0 is hardwired zero, so a pending write to it must never be forwarded.
    assign exmem_hit = exmem_reg_write && (exmem_dst != '0) && (exmem_dst == src_idx);
    assign memwb_hit = memwb_reg_write && (memwb_dst != '0) && (memwb_dst == src_idx);

    // The younger producer (EX/MEM) wins over the older one (MEM/WB).
    always_comb begin
        sel = FWD_REG;
        if (exmem_hit) begin
            sel = FWD_EXMEM;
        end else if (memwb_hit) begin
            sel = FWD_MEMWB;
        end
    end

    always_comb begin
        fwd_data = reg_data;
        case (sel)
            FWD_EXMEM: fwd_data = exmem_result;
            FWD_MEMWB: fwd_data = memwb_wdata;
            default:   fwd_data = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with rs/rt forwarding feeding the ALU
module id_ex_operand_stage #(
    parameter int DATA_W = id_ex_operand_stage_pkg::DATA_W,
    parameter int REG_W  = id_ex_operand_stage_pkg::REG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_dst,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [4:0]        id_alu_conf,
    input  logic              id_sign,
    input  logic              id_alu_src1,
    input  logic              id_alu_src2,
    input  logic              id_reg_write,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_dst,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_dst,
    input  logic [DATA_W-1:0] memwb_wdata,
    output logic [4:0]        alu_conf,
    output logic              alu_sign,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic [REG_W-1:0]  ex_dst
);
    import id_ex_operand_stage_pkg::*;

    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [REG_W-1:0]  ex_rs;
    logic [REG_W-1:0]  ex_rt;
    logic [DATA_W-1:0] ex_imm;
    logic [4:0]        ex_shamt;
    logic              ex_src1;
    logic              ex_src2;
    logic              ex_reg_write_q;

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic [DATA_W-1:0] shamt_operand;
    logic              load_bubble;

    // An invalid ID slot is loaded exactly like a flush so no stray control leaks into EX.
    assign load_bubble = reset || flush || (!stall && !id_valid);

    always_ff @(posedge clk) begin
        if (load_bubble) begin
            ex_valid       <= 1'b0;
            ex_rs_data     <= '0;
            ex_rt_data     <= '0;
            ex_rs          <= '0;
            ex_rt          <= '0;
            ex_dst         <= '0;
            ex_imm         <= '0;
            ex_shamt       <= '0;
            alu_conf       <= ALU_ADD;
            alu_sign       <= 1'b0;
            ex_src1        <= 1'b0;
            ex_src2        <= 1'b0;
            ex_reg_write_q <= 1'b0;
        end else if (!stall) begin
            ex_valid       <= 1'b1;
            ex_rs_data     <= id_rs_data;
            ex_rt_data     <= id_rt_data;
            ex_rs          <= id_rs;
            ex_rt          <= id_rt;
            ex_dst         <= id_dst;
            ex_imm         <= id_imm;
            ex_shamt       <= id_shamt;
            alu_conf       <= id_alu_conf;
            alu_sign       <= id_sign;
            ex_src1        <= id_alu_src1;
            ex_src2        <= id_alu_src2;
            ex_reg_write_q <= id_reg_write;
        end
    end

    // Forwarding stays combinational so stalled operands follow late-arriving producers.
    fwd_select #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
        .src_idx         (ex_rs),
        .reg_data        (ex_rs_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dst       (exmem_dst),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dst       (memwb_dst),
        .memwb_wdata     (memwb_wdata),
        .fwd_data        (fwd_rs)
    );

    fwd_select #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
        .src_idx         (ex_rt),
        .reg_data        (ex_rt_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dst       (exmem_dst),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dst       (memwb_dst),
        .memwb_wdata     (memwb_wdata),
        .fwd_data        (fwd_rt)
    );

    // The ALU takes its shift amount from In1[10:6].
    always_comb begin
        shamt_operand       = '0;
        shamt_operand[10:6] = ex_shamt;
    end

    assign alu_in1       = ex_src1 ? shamt_operand : fwd_rs;
    assign alu_in2       = ex_src2 ? ex_imm : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_reg_write  = ex_reg_write_q & ex_valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - directed self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_dst;
    logic [31:0] id_imm;
    logic [4:0]  id_shamt;
    logic [4:0]  id_alu_conf;
    logic        id_sign;
    logic        id_alu_src1;
    logic        id_alu_src2;
    logic        id_reg_write;
    logic        exmem_reg_write;
    logic [4:0]  exmem_dst;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_dst;
    logic [31:0] memwb_wdata;
    logic [4:0]  alu_conf;
    logic        alu_sign;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] ex_store_data;
    logic        ex_valid;
    logic        ex_reg_write;
    logic [4:0]  ex_dst;

    int checks   = 0;
    int failures = 0;

    id_ex_operand_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_dst          (id_dst),
        .id_imm          (id_imm),
        .id_shamt        (id_shamt),
        .id_alu_conf     (id_alu_conf),
        .id_sign         (id_sign),
        .id_alu_src1     (id_alu_src1),
        .id_alu_src2     (id_alu_src2),
        .id_reg_write    (id_reg_write),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dst       (exmem_dst),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dst       (memwb_dst),
        .memwb_wdata     (memwb_wdata),
        .alu_conf        (alu_conf),
        .alu_sign        (alu_sign),
        .alu_in1         (alu_in1),
        .alu_in2         (alu_in2),
        .ex_store_data   (ex_store_data),
        .ex_valid        (ex_valid),
        .ex_reg_write    (ex_reg_write),
        .ex_dst          (ex_dst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic no_fwd();
        exmem_reg_write = 1'b0;
        exmem_dst       = 5'd0;
        exmem_result    = 32'h0;
        memwb_reg_write = 1'b0;
        memwb_dst       = 5'd0;
        memwb_wdata     = 32'h0;
    endtask

    task automatic load_sub_3_4();
        id_valid     = 1'b1;
        id_rs        = 5'd3;
        id_rs_data   = 32'd5;
        id_rt        = 5'd4;
        id_rt_data   = 32'd7;
        id_dst       = 5'd8;
        id_imm       = 32'h0;
        id_shamt     = 5'd0;
        id_alu_conf  = 5'd3;
        id_sign      = 1'b1;
        id_alu_src1  = 1'b0;
        id_alu_src2  = 1'b0;
        id_reg_write = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        load_sub_3_4();
        no_fwd();

        // reset held two cycles with a valid instruction presented
        tick();
        tick();
        check("rst_conf", {27'b0, alu_conf}, 32'h0);
        check("rst_sign", {31'b0, alu_sign}, 32'h0);
        check("rst_in1", alu_in1, 32'h0);
        check("rst_in2", alu_in2, 32'h0);
        check("rst_store", ex_store_data, 32'h0);
        check("rst_valid", {31'b0, ex_valid}, 32'h0);
        check("rst_regwr", {31'b0, ex_reg_write}, 32'h0);
        check("rst_dst", {27'b0, ex_dst}, 32'h0);

        // plain load, SUB rs=3 rt=4, no hazards
        reset = 1'b0;
        tick();
        check("ld_in1", alu_in1, 32'd5);
        check("ld_in2", alu_in2, 32'd7);
        check("ld_conf", {27'b0, alu_conf}, 32'd3);
        check("ld_sign", {31'b0, alu_sign}, 32'd1);
        check("ld_valid", {31'b0, ex_valid}, 32'd1);
        check("ld_regwr", {31'b0, ex_reg_write}, 32'd1);
        check("ld_dst", {27'b0, ex_dst}, 32'd8);
        check("ld_store", ex_store_data, 32'd7);

        // both producers write rs: EX/MEM wins
        stall = 1'b1;
        exmem_reg_write = 1'b1; exmem_dst = 5'd3; exmem_result = 32'hAA;
        memwb_reg_write = 1'b1; memwb_dst = 5'd3; memwb_wdata  = 32'hBB;
        #1;
        check("fwd_both_in1", alu_in1, 32'hAA);
        check("fwd_both_in2", alu_in2, 32'd7);
        // EX/MEM hits rt, MEM/WB hits rs
        exmem_dst = 5'd4;
        #1;
        check("fwd_split_in1", alu_in1, 32'hBB);
        check("fwd_split_in2", alu_in2, 32'hAA);
        check("fwd_split_store", ex_store_data, 32'hAA);
        // EX/MEM to rs but write enable off: falls to MEM/WB
        exmem_dst = 5'd3; exmem_reg_write = 1'b0;
        #1;
        check("fwd_exmem_off", alu_in1, 32'hBB);
        stall = 1'b0;
        no_fwd();

        // rs = $0 never forwards
        id_rs = 5'd0; id_rs_data = 32'h0;
        tick();
        memwb_reg_write = 1'b1; memwb_dst = 5'd0; memwb_wdata = 32'hFF;
        exmem_reg_write = 1'b1; exmem_dst = 5'd0; exmem_result = 32'h123;
        #1;
        check("zero_in1", alu_in1, 32'h0);
        no_fwd();

        // shamt and immediate operand forms
        load_sub_3_4();
        id_alu_src1 = 1'b1; id_shamt = 5'd7;
        id_alu_src2 = 1'b1; id_imm   = 32'hFFFF_FFFC;
        tick();
        check("shamt_in1", alu_in1, 32'h0000_01C0);
        check("imm_in2", alu_in2, 32'hFFFF_FFFC);
        check("imm_store", ex_store_data, 32'd7);
        stall = 1'b1;
        exmem_reg_write = 1'b1; exmem_dst = 5'd4; exmem_result = 32'h55;
        #1;
        check("imm_store_fwd", ex_store_data, 32'h55);
        check("imm_in2_fwd", alu_in2, 32'hFFFF_FFFC);
        stall = 1'b0;
        no_fwd();

        // stall alone for 3 cycles: fields hold, rt forward tracks EX/MEM
        load_sub_3_4();
        tick();
        stall = 1'b1;
        id_rs_data = 32'd99; id_alu_conf = 5'd1; id_dst = 5'd9; id_reg_write = 1'b0;
        exmem_reg_write = 1'b1; exmem_dst = 5'd4; exmem_result = 32'h11;
        tick();
        check("stall1_in1", alu_in1, 32'd5);
        check("stall1_in2", alu_in2, 32'h11);
        check("stall1_conf", {27'b0, alu_conf}, 32'd3);
        exmem_result = 32'h22;
        tick();
        check("stall2_in2", alu_in2, 32'h22);
        check("stall2_dst", {27'b0, ex_dst}, 32'd8);
        exmem_reg_write = 1'b0;
        tick();
        check("stall3_in2", alu_in2, 32'd7);
        check("stall3_regwr", {31'b0, ex_reg_write}, 32'd1);

        // stall and flush together: bubble
        flush = 1'b1;
        no_fwd();
        tick();
        check("flush_valid", {31'b0, ex_valid}, 32'h0);
        check("flush_conf", {27'b0, alu_conf}, 32'h0);
        check("flush_in1", alu_in1, 32'h0);
        check("flush_regwr", {31'b0, ex_reg_write}, 32'h0);
        stall = 1'b0;
        flush = 1'b0;

        // id_valid = 0 loads a bubble
        load_sub_3_4();
        id_valid = 1'b0;
        tick();
        check("inv_valid", {31'b0, ex_valid}, 32'h0);
        check("inv_regwr", {31'b0, ex_reg_write}, 32'h0);
        check("inv_conf", {27'b0, alu_conf}, 32'h0);
        check("inv_dst", {27'b0, ex_dst}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
